fpu_host_sequencer: RTL and testbench

//  Upstream bus master for the FPU: takes one 32-bit op_a/op_b/opcode request from the host and replays it as byte-wide strobed cycles on the FPU port.

---
 rtl/fpu_host_sequencer.sv | 160 ++++++++++++++++
 tb/tb_fpu_host_sequencer.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_host_sequencer.sv
// fpu_host_sequencer: replays a host A/B/op request as strobed byte cycles on the FPU port and returns the result
module fpu_host_sequencer #(
  parameter int SETUP_CYC   = 1,
  parameter int STROBE_CYC  = 1,
  parameter int HOLD_CYC    = 1,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic        clk,
  input  logic        arst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [7:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic        rsp_err,
  output logic [7:0]  fpu_data_out,
  input  logic [7:0]  fpu_data_in,
  output logic [3:0]  fpu_addr,
  output logic        fpu_cs_n,
  output logic        fpu_rd_n,
  output logic        fpu_wr_n,
  output logic        fpu_end_ack,
  input  logic        fpu_cmd_end,
  input  logic        fpu_busy
);
  typedef enum logic [3:0] {IDLE, WR_SETUP, WR_STROBE, WR_HOLD, WAIT_END, RD_SETUP, RD_STROBE, RD_DONE, ACK, ABORT, RESP} state_t;
  state_t      state_q;
  logic [31:0] cnt_q, cnt_d;
  logic [71:0] pay_q;
  logic [31:0] res_q;
  logic [3:0]  addr_q;
  logic        cs_n_q, rd_n_q, wr_n_q, ack_q, valid_q, err_q;
  logic        phase_done, timed_out;
  assign req_ready    = state_q == IDLE && !fpu_busy && !fpu_cmd_end;
  assign fpu_data_out = pay_q[7:0];
  assign fpu_addr     = addr_q;
  assign fpu_cs_n     = cs_n_q;
  assign fpu_rd_n     = rd_n_q;
  assign fpu_wr_n     = wr_n_q;
  assign fpu_end_ack  = ack_q;
  assign rsp_valid    = valid_q;
  assign rsp_result   = res_q;
  assign rsp_err      = err_q;
  // one counter times every bus phase and also bounds the waits on cmd_end
  always_comb begin
    phase_done = cnt_q == 32'(state_q inside {WR_SETUP, RD_SETUP} ? SETUP_CYC - 1 :
                              state_q inside {WR_STROBE, RD_STROBE} ? STROBE_CYC - 1 : HOLD_CYC - 1);
    timed_out  = cnt_q == 32'(TIMEOUT_CYC - 1);
    cnt_d      = cnt_q + 32'd1;
  end
  // sequencer: write 9 bytes, wait cmd_end, read 4 bytes with rd_n held low, handshake end_ack, respond
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pay_q   <= '0;
      res_q   <= '0;
      addr_q  <= '0;
      cs_n_q  <= 1'b1;
      rd_n_q  <= 1'b1;
      wr_n_q  <= 1'b1;
      ack_q   <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      case (state_q)
        IDLE: if (req_valid && req_ready) begin
          pay_q   <= {req_op, req_b, req_a};
          addr_q  <= 4'd0;
          cs_n_q  <= 1'b0;
          cnt_q   <= '0;
          state_q <= WR_SETUP;
        end
        WR_SETUP: if (phase_done) begin
          wr_n_q  <= 1'b0;
          cnt_q   <= '0;
          state_q <= WR_STROBE;
        end
        WR_STROBE: if (phase_done) begin
          wr_n_q  <= 1'b1;
          cnt_q   <= '0;
          state_q <= WR_HOLD;
        end
        WR_HOLD: if (phase_done) begin
          cnt_q <= '0;
          if (addr_q == 4'd8) begin
            cs_n_q  <= 1'b1;
            state_q <= WAIT_END;
          end else begin
            addr_q  <= addr_q + 4'd1;
            pay_q   <= pay_q >> 8;
            state_q <= WR_SETUP;
          end
        end
        WAIT_END: if (fpu_cmd_end) begin
          addr_q  <= 4'd9;
          cs_n_q  <= 1'b0;
          cnt_q   <= '0;
          state_q <= RD_SETUP;
        end else if (timed_out) begin
          ack_q   <= 1'b1;
          res_q   <= '0;
          err_q   <= 1'b1;
          cnt_q   <= '0;
          state_q <= ABORT;
        end
        RD_SETUP: if (phase_done) begin
          rd_n_q  <= 1'b0;
          cnt_q   <= '0;
          state_q <= RD_STROBE;
        end
        RD_STROBE: if (phase_done) begin
          res_q <= {fpu_data_in, res_q[31:8]};
          cnt_q <= '0;
          if (addr_q == 4'd12) begin
            rd_n_q  <= 1'b1;
            state_q <= RD_DONE;
          end else begin
            addr_q  <= addr_q + 4'd1;
            state_q <= RD_SETUP;
          end
        end
        RD_DONE: begin
          cs_n_q  <= 1'b1;
          ack_q   <= 1'b1;
          cnt_q   <= '0;
          state_q <= ACK;
        end
        ACK: if (!fpu_cmd_end) begin
          ack_q   <= 1'b0;
          valid_q <= 1'b1;
          cnt_q   <= '0;
          state_q <= RESP;
        end else if (timed_out) begin
          res_q   <= '0;
          err_q   <= 1'b1;
          cnt_q   <= '0;
          state_q <= ABORT;
        end
        ABORT: begin
          ack_q   <= 1'b0;
          valid_q <= 1'b1;
          cnt_q   <= '0;
          state_q <= RESP;
        end
        RESP: if (rsp_ready) begin
          valid_q <= 1'b0;
          err_q   <= 1'b0;
          cnt_q   <= '0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fpu_host_sequencer.sv
// tb_fpu_host_sequencer: bus-model FPU plus write/response scoreboards around fpu_host_sequencer
module tb_fpu_host_sequencer;
  localparam int SETUP_CYC   = 1;
  localparam int STROBE_CYC  = 1;
  localparam int HOLD_CYC    = 1;
  localparam int TIMEOUT_CYC = 16;
  localparam logic [7:0] OP_MUL = 8'h03;

  logic        clk = 1'b0, arst = 1'b0;
  logic        req_valid = 1'b0, req_ready;
  logic [7:0]  req_op = 8'h00;
  logic [31:0] req_a = 32'h0, req_b = 32'h0;
  logic        rsp_valid, rsp_ready = 1'b1, rsp_err;
  logic [31:0] rsp_result;
  logic [7:0]  fpu_data_out, fpu_data_in = 8'h00;
  logic [3:0]  fpu_addr;
  logic        fpu_cs_n, fpu_rd_n, fpu_wr_n, fpu_end_ack;
  logic        fpu_cmd_end = 1'b0, fpu_busy = 1'b0;

  int checks = 0, errors = 0;
  logic [11:0] wq[$];
  logic [32:0] rq[$];
  logic [31:0] rword = 32'h0;
  bit end_en = 1'b1, drop_en = 1'b1;

  always #5 clk = ~clk;

  fpu_host_sequencer #(.SETUP_CYC(SETUP_CYC), .STROBE_CYC(STROBE_CYC), .HOLD_CYC(HOLD_CYC), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .clk(clk), .arst(arst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result), .rsp_err(rsp_err),
    .fpu_data_out(fpu_data_out), .fpu_data_in(fpu_data_in), .fpu_addr(fpu_addr),
    .fpu_cs_n(fpu_cs_n), .fpu_rd_n(fpu_rd_n), .fpu_wr_n(fpu_wr_n), .fpu_end_ack(fpu_end_ack),
    .fpu_cmd_end(fpu_cmd_end), .fpu_busy(fpu_busy)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept();
    int n = 0;
    while (n < 200) begin
      @(negedge clk);
      if (req_ready) break;
      n++;
    end
    check("accept", 64'(n < 200), 64'd1);
    tick();
    req_valid = 1'b0;
  endtask

  // queue the nine expected bus writes and the expected response, then issue the request
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [7:0] op, input logic [31:0] rw, input logic [32:0] ex);
    logic [71:0] p;
    p = {op, b, a};
    for (int k = 0; k < 9; k++) wq.push_back({4'(k), p[8*k +: 8]});
    rq.push_back(ex);
    rword = rw;
    req_a = a;
    req_b = b;
    req_op = op;
    req_valid = 1'b1;
    accept();
  endtask

  task automatic wait_rsp();
    int n = 0;
    while (rq.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("rsp_done", 64'(rq.size()), 64'd0);
    rq.delete();
    tick();
  endtask

  initial begin
    fork
      // FPU bus model, write checker and response checker
      begin : mon
        logic [11:0] e;
        int  wr_cnt = 0, wr_low = 0, rdly = 0, ddly = 0;
        bit  wr_prev = 1'b1, rd_prev = 1'b1, raised = 1'b0, ack_seen = 1'b0, drop_chk = 1'b0;
        forever begin
          @(negedge clk);
          if (!fpu_wr_n && wr_prev) begin
            if (wq.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL wr_unexp actual=%0h required=none", {fpu_addr, fpu_data_out});
            end else begin
              e = wq.pop_front();
              check("wr_byte", {fpu_cs_n, fpu_addr, fpu_data_out}, {1'b0, e});
            end
            if (fpu_addr == 4'd0) raised = 1'b0;
            wr_cnt = fpu_addr == 4'd0 ? 1 : wr_cnt + 1;
            wr_low = 0;
          end
          if (!fpu_wr_n) wr_low++;
          if (fpu_wr_n && !wr_prev && arst) check("wr_width", 64'(wr_low), 64'(STROBE_CYC));
          if (fpu_rd_n && !rd_prev && arst) check("rd_cont", 64'(fpu_addr), 64'd12);
          wr_prev = fpu_wr_n;
          rd_prev = fpu_rd_n;
          fpu_data_in = (!fpu_cs_n && fpu_addr >= 4'd9) ? 8'(rword >> (8 * (fpu_addr - 4'd9))) : 8'h00;
          if (fpu_cmd_end && fpu_end_ack) ack_seen = 1'b1;
          if (drop_chk) begin
            check("ack_drop", 64'(fpu_end_ack), 64'd0);
            drop_chk = 1'b0;
          end
          if (!fpu_cmd_end && fpu_cs_n && wr_cnt == 9 && !raised && end_en) begin
            if (rdly == 2) begin
              fpu_cmd_end = 1'b1;
              raised = 1'b1;
              rdly = 0;
            end else rdly++;
          end
          if (fpu_cmd_end && ack_seen && drop_en) begin
            if (ddly == 2) begin
              drop_chk = fpu_end_ack;
              fpu_cmd_end = 1'b0;
              ack_seen = 1'b0;
              ddly = 0;
            end else ddly++;
          end
          if (rsp_valid) wr_cnt = 0;
          if (rsp_valid && rsp_ready) begin
            if (rq.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL rsp_unexp actual=%0h required=none", {rsp_err, rsp_result});
            end else check("rsp", {rsp_err, rsp_result}, rq.pop_front());
          end
        end
      end
      // directed stimulus
      begin : stim
        int n, bad, cyc, acks;
        repeat (3) @(negedge clk);
        check("reset_out", {fpu_cs_n, fpu_rd_n, fpu_wr_n, fpu_addr, fpu_data_out, fpu_end_ack, rsp_valid, rsp_result, rsp_err},
              {3'b111, 4'h0, 8'h00, 1'b0, 1'b0, 32'h0, 1'b0});
        check("reset_ready", 64'(req_ready), 64'd1);
        tick();
        arst = 1'b1;
        tick();
        // 23.0 * 47.0 = 1081.0
        send(32'h41b80000, 32'h423c0000, OP_MUL, 32'h44872000, {1'b0, 32'h44872000});
        wait_rsp();
        // byte ordering on writes and reads
        send(32'h44332211, 32'h88776655, 8'h99, 32'hEFBEADDE, {1'b0, 32'hEFBEADDE});
        wait_rsp();
        // busy FPU blocks acceptance and bus activity
        fpu_busy = 1'b1;
        req_a = 32'h3f800000;
        req_b = 32'h3f800000;
        req_op = OP_MUL;
        req_valid = 1'b1;
        bad = 0;
        repeat (20) begin
          @(negedge clk);
          if (req_ready || !fpu_cs_n || !fpu_wr_n) bad++;
        end
        check("busy_block", 64'(bad), 64'd0);
        tick();
        fpu_busy = 1'b0;
        send(32'h3f800000, 32'h3f800000, OP_MUL, 32'h3f800000, {1'b0, 32'h3f800000});
        wait_rsp();
        // response held while rsp_ready is low; a second request waits
        rsp_ready = 1'b0;
        send(32'h3f800000, 32'h40000000, OP_MUL, 32'h40000000, {1'b0, 32'h40000000});
        n = 0;
        while (!rsp_valid && n < 500) begin
          @(negedge clk);
          n++;
        end
        check("rsp_wait", 64'(rsp_valid), 64'd1);
        req_a = 32'hdeadbeef;
        req_b = 32'h1;
        req_op = 8'h11;
        req_valid = 1'b1;
        bad = 0;
        repeat (50) begin
          @(negedge clk);
          if (!rsp_valid || rsp_result !== 32'h40000000 || rsp_err || req_ready || !fpu_cs_n) bad++;
        end
        check("rsp_hold", 64'(bad), 64'd0);
        req_valid = 1'b0;
        tick();
        rsp_ready = 1'b1;
        wait_rsp();
        // cmd_end never rises: abort after TIMEOUT_CYC wait cycles plus the end_ack pulse
        end_en = 1'b0;
        send(32'h00000001, 32'h00000002, 8'h01, 32'h12345678, {1'b1, 32'h0});
        n = 0;
        while (!fpu_cs_n && n < 200) begin
          @(negedge clk);
          n++;
        end
        cyc = 0;
        acks = 0;
        while (!rsp_valid && cyc < 100) begin
          @(negedge clk);
          cyc++;
          if (fpu_end_ack) acks++;
        end
        check("to_cycles", 64'(cyc), 64'(TIMEOUT_CYC + 1));
        check("to_ack_pulse", 64'(acks), 64'd1);
        wait_rsp();
        end_en = 1'b1;
        // cmd_end never falls after end_ack: abort from ACK
        drop_en = 1'b0;
        send(32'h0000abcd, 32'h00001234, 8'h02, 32'h55aa55aa, {1'b1, 32'h0});
        wait_rsp();
        drop_en = 1'b1;
        n = 0;
        while (fpu_cmd_end && n < 50) begin
          @(negedge clk);
          n++;
        end
        check("cmd_end_low", 64'(fpu_cmd_end), 64'd0);
        tick();
        // async reset in the middle of a write strobe
        wq.push_back({4'd0, 8'h01});
        wq.push_back({4'd1, 8'h02});
        wq.push_back({4'd2, 8'h03});
        req_a = 32'h04030201;
        req_b = 32'h0;
        req_op = 8'h00;
        req_valid = 1'b1;
        accept();
        n = 0;
        while (!(!fpu_wr_n && fpu_addr == 4'd2) && n < 100) begin
          @(negedge clk);
          n++;
        end
        arst = 1'b0;
        #1;
        check("rst_strobes", {fpu_wr_n, fpu_cs_n, fpu_rd_n}, 3'b111);
        check("rst_wq", 64'(wq.size()), 64'd0);
        wq.delete();
        tick();
        arst = 1'b1;
        tick();
        send(32'hcafef00d, 32'h0badc0de, 8'h5a, 32'h01020304, {1'b0, 32'h01020304});
        wait_rsp();
        repeat (3) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
      end
    join_any
  end
endmodule
